// File: rtl/disp_page_scheduler.sv
// disp_page_scheduler: time-shares a 4-digit hex display across NUM_SRC 32-bit debug words, two pages each.
// Define DISP_ALERT_EN to build the alert override (ALERT state, alert counter, alert ports).
module disp_page_scheduler #(
   parameter int NUM_SRC          = 4,
   parameter int DWELL_CYCLES     = 5_000_000,
   parameter int DEBOUNCE_CYCLES  = 500_000,
   parameter int ALERT_MIN_CYCLES = 2_500_000
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [32*NUM_SRC-1:0]         src_data,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic                          step_btn,
   input  logic                          auto_en,
   input  logic                          freeze,
   input  logic                          alert_req,
   input  logic [15:0]                   alert_data,
   output logic [15:0]                   hex_val,
   output logic [$clog2(2*NUM_SRC)-1:0]  page_idx,
   output logic [3:0]                    dp_mask,
   output logic                          alert_active,
   output logic                          no_src
);
   localparam int P   = 2 * NUM_SRC;
   localparam int PW  = $clog2(P);
   localparam int DWW = $clog2(DWELL_CYCLES);
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DWW-1:0] DW_MAX = DWW'(DWELL_CYCLES - 1);
   localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      MANUAL,
      ROTATE
`ifdef DISP_ALERT_EN
      , ALERT
`endif
   } state_t;

   state_t          state, nxt_state;
   logic [1:0]      sync;
   logic            deb_lvl, step_p;
   logic [DBW-1:0]  deb_cnt;
   logic [DWW-1:0]  dwell_cnt, dwell_nxt;
   logic [PW-1:0]   page_nxt;
   logic [P-1:0]    pv;
   logic [15:0]     shown, hex_nxt;

   // First valid page after cur, wrapping; smallest offset wins, cur itself is the last resort.
   function automatic logic [PW-1:0] adv(input logic [PW-1:0] cur, input logic [P-1:0] v);
      logic [PW-1:0] r;
      int c;
      r = cur;
      for (int k = P - 1; k >= 1; k--) begin
         c = (int'(cur) + k) % P;
         if (v[PW'(c)]) r = PW'(c);
      end
      return r;
   endfunction

`ifdef DISP_ALERT_EN
   localparam int AW = $clog2(ALERT_MIN_CYCLES + 1);
   localparam logic [AW-1:0] AL_MAX = AW'(ALERT_MIN_CYCLES - 1);
   logic [AW-1:0] acnt, acnt_nxt;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) acnt <= '0;
      else acnt <= acnt_nxt;
   assign alert_active = (state == ALERT);
`else
   logic unused_alert;
   assign unused_alert = ^{alert_req, alert_data};
   assign alert_active = 1'b0;
`endif

   always_comb begin
      for (int j = 0; j < P; j++) pv[j] = src_valid[j/2];
      page_nxt  = page_idx;
      dwell_nxt = dwell_cnt;
      nxt_state = auto_en ? ROTATE : MANUAL;
      if (state == MANUAL) begin
         dwell_nxt = '0;
         if (!freeze && step_p) page_nxt = adv(page_idx, pv);
      end else if (!freeze) begin
         if (step_p || dwell_cnt == DW_MAX) begin
            page_nxt  = adv(page_idx, pv);
            dwell_nxt = '0;
         end else dwell_nxt = dwell_cnt + 1'b1;
      end
`ifdef DISP_ALERT_EN
      acnt_nxt = acnt;
      if (state == ALERT) begin
         page_nxt  = page_idx;
         dwell_nxt = '0;
         acnt_nxt  = (acnt == AL_MAX) ? acnt : acnt + 1'b1;
         if (alert_req || acnt != AL_MAX) begin
            nxt_state = ALERT;
            dwell_nxt = dwell_cnt;
         end
      end else if (alert_req) begin
         nxt_state = ALERT;
         page_nxt  = page_idx;
         dwell_nxt = dwell_cnt;
         acnt_nxt  = '0;
      end
`endif
      shown   = pv[page_nxt] ? src_data[{page_nxt, 4'b0000} +: 16] : 16'h0000;
      hex_nxt = freeze ? hex_val : shown;
`ifdef DISP_ALERT_EN
      if (nxt_state == ALERT) hex_nxt = alert_data;
      else if (state == ALERT) hex_nxt = shown;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= MANUAL;
         page_idx  <= '0;
         dwell_cnt <= '0;
         hex_val   <= '0;
         no_src    <= 1'b0;
         sync      <= '0;
         deb_lvl   <= 1'b0;
         deb_cnt   <= '0;
         step_p    <= 1'b0;
      end else begin
         state     <= nxt_state;
         page_idx  <= page_nxt;
         dwell_cnt <= dwell_nxt;
         hex_val   <= hex_nxt;
         no_src    <= ~|src_valid;
         sync      <= {sync[0], step_btn};
         step_p    <= sync[1] && !deb_lvl && deb_cnt == DB_MAX;
         if (sync[1] == deb_lvl) deb_cnt <= '0;
         else if (deb_cnt == DB_MAX) begin
            deb_cnt <= '0;
            deb_lvl <= sync[1];
         end else deb_cnt <= deb_cnt + 1'b1;
      end
   end

   assign dp_mask = alert_active ? 4'b1111 : page_idx[0] ? 4'b1000 : 4'b0001;
endmodule

// File: tb/tb_disp_page_scheduler.sv
// tb_disp_page_scheduler: directed scoreboard bench for disp_page_scheduler (NUM_SRC=4, dwell 8, debounce 4, alert min 6).
module tb_disp_page_scheduler;
   logic        clk = 1'b0;
   logic        reset_n, step_btn, auto_en, freeze, alert_req, alert_active, no_src;
   logic [31:0] src [4];
   logic [127:0] src_data;
   logic [3:0]  src_valid, dp_mask;
   logic [15:0] alert_data, hex_val;
   logic [2:0]  page_idx;
   int          vectors = 0, miscompares = 0;

   typedef struct {
      string       tag;
      logic [2:0]  page;
      logic [15:0] hex;
      logic [3:0]  dp;
      logic        al;
      logic        ns;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;
   assign src_data = {src[3], src[2], src[1], src[0]};

   disp_page_scheduler #(.NUM_SRC(4), .DWELL_CYCLES(8), .DEBOUNCE_CYCLES(4), .ALERT_MIN_CYCLES(6)) dut (
      .clk(clk), .reset_n(reset_n), .src_data(src_data), .src_valid(src_valid), .step_btn(step_btn),
      .auto_en(auto_en), .freeze(freeze), .alert_req(alert_req), .alert_data(alert_data),
      .hex_val(hex_val), .page_idx(page_idx), .dp_mask(dp_mask), .alert_active(alert_active), .no_src(no_src)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] ehex(input int p);
      logic [31:0] w;
      w = src[p/2];
      if (!src_valid[p/2]) return 16'h0000;
      return p[0] ? w[31:16] : w[15:0];
   endfunction

   task automatic push(input string tag, input int p, input logic [15:0] hex, input logic [3:0] dp,
                       input logic al, input logic ns);
      exp_t e;
      e.tag = tag; e.page = 3'(p); e.hex = hex; e.dp = dp; e.al = al; e.ns = ns;
      q.push_back(e);
   endtask

   task automatic pushn(input string tag, input int p);
      push(tag, p, ehex(p), p[0] ? 4'b1000 : 4'b0001, 1'b0, src_valid == 4'b0000);
   endtask

   task automatic cmp(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s.%s: observed %h expected %h", tag, field, obs, exp);
      end
   endtask

   task automatic pop_check();
      exp_t e;
      if (q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
         return;
      end
      e = q.pop_front();
      cmp(e.tag, "page", 32'(page_idx), 32'(e.page));
      cmp(e.tag, "hex", 32'(hex_val), 32'(e.hex));
      cmp(e.tag, "dp", 32'(dp_mask), 32'(e.dp));
      cmp(e.tag, "alert", 32'(alert_active), 32'(e.al));
      cmp(e.tag, "no_src", 32'(no_src), 32'(e.ns));
   endtask

   initial begin
      int skip_seq[4] = '{1, 4, 5, 0};
      int glitch[8]   = '{1, 1, 0, 0, 1, 1, 0, 0};
      reset_n = 1'b0; step_btn = 1'b0; auto_en = 1'b1; freeze = 1'b0; alert_req = 1'b0; alert_data = 16'hBEEF;
      src[0] = 32'h1234ABCD; src[1] = 32'h55AA0F0F; src[2] = 32'hC0DEF00D; src[3] = 32'h0BADCAFE;
      src_valid = 4'hF;
      tick(2);
      push("reset", 0, 16'h0000, 4'b0001, 1'b0, 1'b0); pop_check();
      reset_n = 1'b1;
      pushn("boot", 0); tick(1); pop_check();
      pushn("dwell_hold", 0); tick(7); pop_check();
      for (int p = 1; p < 8; p++) begin
         pushn("rotate", p); tick(p == 1 ? 1 : 8); pop_check();
      end
      pushn("wrap", 0); tick(8); pop_check();
      src_valid = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         pushn("skip", skip_seq[i]); tick(8); pop_check();
      end
      src_valid = 4'b0000;
      pushn("none", 0); tick(1); pop_check();
      pushn("none_hold", 0); tick(8); pop_check();
      src_valid = 4'hF; auto_en = 1'b0;
      pushn("to_manual", 0); tick(2); pop_check();
      for (int i = 0; i < 8; i++) begin
         step_btn = glitch[i][0]; tick(1);
      end
      pushn("glitch", 0); tick(10); pop_check();
      step_btn = 1'b1;
      pushn("deb_wait", 0); tick(6); pop_check();
      pushn("deb_step", 1); tick(1); pop_check();
      tick(3); step_btn = 1'b0;
      pushn("deb_once", 1); tick(10); pop_check();
      auto_en = 1'b1;
      tick(5);
      freeze = 1'b1; step_btn = 1'b1; src[0] = 32'h11112222;
      tick(7); step_btn = 1'b0;
      push("frozen", 1, 16'h1234, 4'b1000, 1'b0, 1'b0); tick(8); pop_check();
      freeze = 1'b0;
      pushn("thaw", 1); tick(1); pop_check();
      pushn("resume", 1); tick(2); pop_check();
      pushn("resume_exp", 2); tick(1); pop_check();
      tick(1); step_btn = 1'b1;
      pushn("coll_pre", 2); tick(6); pop_check();
      pushn("coll", 3); tick(1); pop_check();
      step_btn = 1'b0;
      pushn("coll_clr", 3); tick(7); pop_check();
      pushn("coll_next", 4); tick(1); pop_check();
`ifdef DISP_ALERT_EN
      alert_req = 1'b1;
      push("alert_on", 4, 16'hBEEF, 4'b1111, 1'b1, 1'b0); tick(1); pop_check();
      tick(1); alert_req = 1'b0;
      push("alert_hold", 4, 16'hBEEF, 4'b1111, 1'b1, 1'b0); tick(4); pop_check();
      pushn("alert_exit", 4); tick(1); pop_check();
      pushn("alert_dwell", 4); tick(7); pop_check();
      pushn("alert_adv", 5); tick(1); pop_check();
`else
      alert_req = 1'b1;
      pushn("alert_ign", 4); tick(1); pop_check();
      pushn("alert_ign_dwell", 4); tick(6); pop_check();
      pushn("alert_ign_adv", 5); tick(1); pop_check();
      alert_req = 1'b0;
`endif
      tick(3);
      reset_n = 1'b0; #1;
      push("reset_async", 0, 16'h0000, 4'b0001, 1'b0, 1'b0); pop_check();
      tick(2);
      push("reset_held", 0, 16'h0000, 4'b0001, 1'b0, 1'b0); pop_check();
      reset_n = 1'b1;
      pushn("release", 0); tick(1); pop_check();
      pushn("release_hold", 0); tick(7); pop_check();
      pushn("release_adv", 1); tick(1); pop_check();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/disp_page_scheduler.md
# disp_page_scheduler

Time-shares the four-digit hex display between up to NUM_SRC 32-bit debug sources, such as CPU instruction, PC and memory data-out. Each source becomes two 16-bit pages: low half first, then high half. Pages are sequenced by an auto-rotation dwell timer or by a debounced step button, with an optional alert override. The block sits between the CPU debug outputs and the hex display driver, and feeds its 16-bit hex value input plus a decimal-point page indicator.

## Interface
- NUM_SRC, 4: number of 32-bit sources; must be at least 1. Page count P = 2*NUM_SRC.
- DWELL_CYCLES, 5_000_000: clk cycles each page is shown in auto mode; must be at least 2.
- DEBOUNCE_CYCLES, 500_000: consecutive stable samples needed to accept a button level.
- ALERT_MIN_CYCLES, 2_500_000: minimum alert display time.
- clk  input  1  sole clock; all logic is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- src_data  input  32*NUM_SRC  source i occupies bits [32*i+31:32*i].
- src_valid  input  NUM_SRC  source i may be displayed when its bit is 1.
- step_btn  input  1  raw, asynchronous pushbutton; active-high.
- auto_en  input  1  1 = auto-rotate, 0 = manual.
- freeze  input  1  holds both the page and hex_val.
- alert_req  input  1  level request for the alert override.
- alert_data  input  16  value shown during an alert.
- hex_val  output  16  registered value for the display.
- page_idx  output  clog2(P) (minimum 1)  current page; source = page_idx>>1, half = page_idx[0].
- dp_mask  output  4  active-high decimal points; the display driver inverts them.
- alert_active  output  1  high while in the ALERT state.
- no_src  output  1  high when no src_valid bit is set.

## Operation
- Button path: 2-FF synchronizer, then a debounce counter. The counter resets whenever the synchronized level differs from the debounced level. The level is accepted after DEBOUNCE_CYCLES equal samples. A rising edge of the debounced level produces a one-cycle step pulse.
- Advance: page_idx moves to the next page, modulo P, whose source has src_valid=1. Scanning is combinational over all P pages.
  - If the current source is the only valid one, its two halves alternate.
  - If no source is valid: page_idx holds, no_src=1, hex_val=16'h0000.
- States:
  - ROTATE (auto_en=1): the dwell counter counts 0..DWELL_CYCLES-1. On expiry the page advances and the counter returns to 0. A step pulse advances immediately and clears the counter.
  - MANUAL (auto_en=0): the dwell counter is held at 0; only step pulses advance.
  - ALERT: entered from ROTATE or MANUAL when alert_req=1.
    - hex_val = alert_data (sampled every cycle); dp_mask = 4'b1111; the dwell counter is paused.
    - Step pulses are dropped.
    - Exit when alert_req=0 and at least ALERT_MIN_CYCLES cycles have elapsed since entry. Return to ROTATE or MANUAL according to auto_en, on the page held before the alert, with the dwell counter cleared.
- auto_en changes take effect on the next cycle; the dwell counter clears on a MANUAL to ROTATE transition.
- freeze=1 outside ALERT:
  - hex_val and page_idx hold.
  - Step pulses and dwell expiry are dropped; the dwell counter holds its value.
  - Releasing freeze resumes counting from the held value.
- Per-cycle priority: reset > alert > freeze > step > dwell expiry. A step pulse and a dwell expiry in the same cycle give exactly one advance.
- Normal display:
  - hex_val = the selected 16-bit half of the current source.
  - dp_mask = 4'b0001 for the low half, 4'b1000 for the high half.
- If the current page's source becomes invalid, hex_val shows 16'h0000 until the next advance. The page is not forced to change.

## Timing
- Reset values of outputs: hex_val=0, page_idx=0, dp_mask=4'b0001, alert_active=0, no_src=0.
- Reset values of internal state: FSM state = MANUAL; dwell counter, debounce counter and alert counter = 0; debounced level = 0. State re-evaluates on the first clock after reset.
- Reset asserted mid-operation clears all state asynchronously. No advance occurs on reset release.
- hex_val latency: one clk from src_data, alert_data or page change.
- Button latency: step pulse occurs 2 + DEBOUNCE_CYCLES cycles after a clean step_btn rise; page_idx updates one cycle later.
- Auto-mode pages change every DWELL_CYCLES cycles exactly.
- alert_active rises one cycle after alert_req rises. It falls max(req low, ALERT_MIN_CYCLES after entry) + 1 cycle.

## Configuration
- DISP_ALERT_EN defined: ALERT state, alert counter and alert ports are functional.
- DISP_ALERT_EN undefined: no ALERT state is implemented; alert_req and alert_data are ignored; alert_active is tied 0. The rest of the behaviour is unchanged.

## Test plan
Bench parameters: NUM_SRC=4, DWELL_CYCLES=8, DEBOUNCE_CYCLES=4, ALERT_MIN_CYCLES=6.
- Auto rotation: src_valid=4'b1111, src0=32'h1234ABCD, auto_en=1 -> hex_val=ABCD, then 1234 after 8 cycles with dp_mask 0001 then 1000; page_idx cycles 0..7 and wraps to 0.
- Skip and none: src_valid=4'b0101 -> page sequence 0,1,4,5,0. With src_valid=0 -> no_src=1, hex_val=0000, page_idx frozen.
- Debounce: auto_en=0, step_btn bounces 1-0-1 with 2-cycle pulses, then holds high for 10 cycles -> exactly one advance, page_idx changes 7 cycles after the stable rise; glitches alone cause no advance.
- Alert: alert_req=1 for 2 cycles with alert_data=BEEF -> hex_val=BEEF, dp_mask=1111 held for 6 cycles, then the prior page is restored with a fresh dwell count.
- Freeze and collisions: freeze=1 over a dwell expiry and a step -> no change; after release, a step coincident with a dwell expiry -> single advance. Reset_n pulsed mid-dwell -> all outputs at their reset values immediately.
- With DISP_ALERT_EN undefined: alert_req=1 -> alert_active=0 and rotation continues unchanged.
